// File: rtl/dcache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// dcache_ctrl_fsm
// Control FSM for a WAYS-way, BLKWORDS-word-per-block data cache in the
// coherent pipeline. Sits between the dcache tag/data arrays and the
// coherence controller / memory bus: detects hits, sequences write-backs,
// fills and write-upgrades, services snoops, and flushes dirty lines on halt.
//
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   dmemREN/WEN/addr     processor request, held until hit
//   halt                 processor halted; starts the dirty flush
//   way_hit, hit_dirty   tag lookup of dmemaddr
//   victim               LRU victim way of dmemaddr's set
//   victim_dirty/_tag    entry under victim (or under fl_set/fl_way while flushing)
//   dwait                bus busy
//   ccwait, ccinv        snoop pending / snoop invalidates
//   ccsnoopaddr          snooped address
//   snoop_way/hit/dirty  datapath lookup of ccsnoopaddr
//   dREN, dWEN, daddr    bus word read / write and word address
//   cctrans, ccwrite     coherence transaction active / intent-to-modify
//   hit                  request satisfied this cycle
//   fill_en/_way         write fetched word into fill_way at word_idx
//   word_idx             word counter of the current block transfer
//   clr_dirty, inv_en    clear dirty / valid of the current context entry
//   fl_set, fl_way       flush entry pointer
//   flushing, flushed    flush in progress / flush complete
// -----------------------------------------------------------------------------
// state  | meaning
// IDLE   | waiting; serves hits, clean snoops, dispatches misses/halt
// WB     | writing dirty victim block back before a fill
// FETCH  | reading requested block into the victim way
// UPG    | write-upgrade bus transaction for a clean write hit
// SNP_WB | writing a snooped dirty block back to memory
// FL_CHK | inspecting flush entry (fl_set, fl_way)
// FL_WB  | writing back a dirty flush entry
// HALTED | flush complete, terminal until reset
// -----------------------------------------------------------------------------
module dcache_ctrl_fsm #(
    parameter  int WAYS     = 2,
    parameter  int BLKWORDS = 2,
    parameter  int SETS     = 8,
    localparam int WAYW     = $clog2(WAYS),
    localparam int OFFW     = $clog2(BLKWORDS),
    localparam int IDXW     = $clog2(SETS),
    localparam int TAGW     = 30 - OFFW - IDXW
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            dmemREN,
    input  logic            dmemWEN,
    input  logic [31:0]     dmemaddr,
    input  logic            halt,
    input  logic [WAYS-1:0] way_hit,
    input  logic            hit_dirty,
    input  logic [WAYW-1:0] victim,
    input  logic            victim_dirty,
    input  logic [TAGW-1:0] victim_tag,
    input  logic            dwait,
    input  logic            ccwait,
    input  logic            ccinv,
    input  logic [31:0]     ccsnoopaddr,
    input  logic [WAYW-1:0] snoop_way,
    input  logic            snoop_hit,
    input  logic            snoop_dirty,
    output logic            dREN,
    output logic            dWEN,
    output logic [31:0]     daddr,
    output logic            cctrans,
    output logic            ccwrite,
    output logic            hit,
    output logic            fill_en,
    output logic [WAYW-1:0] fill_way,
    output logic [OFFW-1:0] word_idx,
    output logic            clr_dirty,
    output logic            inv_en,
    output logic [IDXW-1:0] fl_set,
    output logic [WAYW-1:0] fl_way,
    output logic            flushing,
    output logic            flushed
);

    typedef enum logic [2:0] {
        IDLE, WB, FETCH, UPG, SNP_WB, FL_CHK, FL_WB, HALTED
    } state_t;

    state_t          state, stateNxt;
    logic [OFFW-1:0] wordIdx, wordIdxNxt;
    logic [IDXW-1:0] flSet, flSetNxt;
    logic [WAYW-1:0] flWay, flWayNxt;
    logic [WAYW-1:0] victimLat, victimNxt;
    logic            snpFromFl, snpFromFlNxt;
    logic            upgDone, upgDoneNxt;

    logic            lastWord;
    logic            flLast;
    logic [IDXW+WAYW-1:0] flNext;
    logic [IDXW-1:0] reqIdx;
    logic            unusedBits;

    assign lastWord = (wordIdx == OFFW'(BLKWORDS - 1));
    assign flLast   = (flSet == IDXW'(SETS - 1)) && (flWay == WAYW'(WAYS - 1));
    // way is the low-order digit, so ways advance before sets
    assign flNext   = {flSet, flWay} + 1'b1;
    assign reqIdx   = dmemaddr[2+OFFW +: IDXW];

    // snoop_way only steers the datapath; the word bits of the snoop address
    // are replaced by the transfer counter
    assign unusedBits = ^{snoop_way, ccsnoopaddr[1+OFFW:0]};

    assign fill_way = victimLat;
    assign word_idx = wordIdx;
    assign fl_set   = flSet;
    assign fl_way   = flWay;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            wordIdx   <= '0;
            flSet     <= '0;
            flWay     <= '0;
            victimLat <= '0;
            snpFromFl <= 1'b0;
            upgDone   <= 1'b0;
        end else begin
            state     <= stateNxt;
            wordIdx   <= wordIdxNxt;
            flSet     <= flSetNxt;
            flWay     <= flWayNxt;
            victimLat <= victimNxt;
            snpFromFl <= snpFromFlNxt;
            upgDone   <= upgDoneNxt;
        end
    end

    always_comb begin
        stateNxt     = state;
        wordIdxNxt   = wordIdx;
        flSetNxt     = flSet;
        flWayNxt     = flWay;
        victimNxt    = victimLat;
        snpFromFlNxt = snpFromFl;
        upgDoneNxt   = upgDone;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        daddr        = '0;
        cctrans      = 1'b0;
        ccwrite      = 1'b0;
        hit          = 1'b0;
        fill_en      = 1'b0;
        clr_dirty    = 1'b0;
        inv_en       = 1'b0;
        flushing     = 1'b0;
        flushed      = 1'b0;

        case (state)
            IDLE: begin
                if (ccwait) begin
                    if (snoop_hit && snoop_dirty) begin
                        stateNxt     = SNP_WB;
                        wordIdxNxt   = '0;
                        snpFromFlNxt = 1'b0;
                    end else begin
                        inv_en = snoop_hit & ccinv;
                    end
                end else begin
                    // a completed upgrade is only good for the very next look
                    upgDoneNxt = 1'b0;
                    if (dmemREN || dmemWEN) begin
                        if (|way_hit) begin
                            if (dmemREN || hit_dirty || upgDone) begin
                                hit = 1'b1;
                            end else begin
                                stateNxt = UPG;
                            end
                        end else begin
                            victimNxt  = victim;
                            wordIdxNxt = '0;
                            stateNxt   = victim_dirty ? WB : FETCH;
                        end
                    end else if (halt) begin
                        stateNxt = FL_CHK;
                        flSetNxt = '0;
                        flWayNxt = '0;
                    end
                end
            end

            UPG: begin
                cctrans = 1'b1;
                ccwrite = 1'b1;
                daddr   = dmemaddr;
                if (!dwait) begin
                    stateNxt   = IDLE;
                    upgDoneNxt = 1'b1;
                end
            end

            WB: begin
                dWEN      = 1'b1;
                cctrans   = 1'b1;
                daddr     = {victim_tag, reqIdx, wordIdx, 2'b00};
                clr_dirty = lastWord;
                if (!dwait) begin
                    if (lastWord) begin
                        stateNxt   = FETCH;
                        wordIdxNxt = '0;
                    end else begin
                        wordIdxNxt = wordIdx + 1'b1;
                    end
                end
            end

            FETCH: begin
                dREN    = 1'b1;
                cctrans = 1'b1;
                ccwrite = dmemWEN;
                daddr   = {dmemaddr[31:2+OFFW], wordIdx, 2'b00};
                if (!dwait) begin
                    fill_en = 1'b1;
                    if (lastWord) begin
                        stateNxt   = IDLE;
                        wordIdxNxt = '0;
                    end else begin
                        wordIdxNxt = wordIdx + 1'b1;
                    end
                end
            end

            SNP_WB: begin
                dWEN     = 1'b1;
                daddr    = {ccsnoopaddr[31:2+OFFW], wordIdx, 2'b00};
                flushing = snpFromFl;
                if (lastWord) begin
                    clr_dirty = 1'b1;
                    inv_en    = ccinv;
                end
                if (!dwait) begin
                    if (lastWord) begin
                        stateNxt   = snpFromFl ? FL_CHK : IDLE;
                        wordIdxNxt = '0;
                    end else begin
                        wordIdxNxt = wordIdx + 1'b1;
                    end
                end
            end

            FL_CHK: begin
                flushing = 1'b1;
                if (ccwait) begin
                    if (snoop_hit && snoop_dirty) begin
                        stateNxt     = SNP_WB;
                        wordIdxNxt   = '0;
                        snpFromFlNxt = 1'b1;
                    end else begin
                        inv_en = snoop_hit & ccinv;
                    end
                end else if (victim_dirty) begin
                    stateNxt   = FL_WB;
                    wordIdxNxt = '0;
                end else if (flLast) begin
                    stateNxt = HALTED;
                end else begin
                    {flSetNxt, flWayNxt} = flNext;
                end
            end

            FL_WB: begin
                flushing  = 1'b1;
                dWEN      = 1'b1;
                cctrans   = 1'b1;
                daddr     = {victim_tag, flSet, wordIdx, 2'b00};
                clr_dirty = lastWord;
                if (!dwait) begin
                    if (lastWord) begin
                        wordIdxNxt = '0;
                        if (flLast) begin
                            stateNxt = HALTED;
                        end else begin
                            stateNxt = FL_CHK;
                            {flSetNxt, flWayNxt} = flNext;
                        end
                    end else begin
                        wordIdxNxt = wordIdx + 1'b1;
                    end
                end
            end

            HALTED: begin
                flushed = 1'b1;
            end

            default: begin
                stateNxt = IDLE;
            end
        endcase

        // the Mealy outputs must also read zero while reset is held
        if (!nRST) begin
            hit    = 1'b0;
            inv_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
module tb_dcache_ctrl_fsm;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, halt;
    logic [31:0] dmemaddr;
    logic [1:0]  way_hit;
    logic        hit_dirty;
    logic [0:0]  victim;
    logic        victim_dirty;
    logic [25:0] victim_tag;
    logic        dwait, ccwait, ccinv;
    logic [31:0] ccsnoopaddr;
    logic [0:0]  snoop_way;
    logic        snoop_hit, snoop_dirty;
    logic        dREN, dWEN, cctrans, ccwrite, hit, fill_en;
    logic [31:0] daddr;
    logic [0:0]  fill_way, word_idx, fl_way;
    logic        clr_dirty, inv_en, flushing, flushed;
    logic [2:0]  fl_set;

    int nAsserts = 0;
    int nFails   = 0;

    // cache array model standing in for the datapath
    logic        mValid [8][2];
    logic        mDirty [8][2];
    logic [25:0] mTag   [8][2];

    dcache_ctrl_fsm #(.WAYS(2), .BLKWORDS(2), .SETS(8)) dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .halt(halt), .way_hit(way_hit), .hit_dirty(hit_dirty),
        .victim(victim), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .snoop_way(snoop_way), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .cctrans(cctrans), .ccwrite(ccwrite),
        .hit(hit), .fill_en(fill_en), .fill_way(fill_way), .word_idx(word_idx),
        .clr_dirty(clr_dirty), .inv_en(inv_en), .fl_set(fl_set), .fl_way(fl_way),
        .flushing(flushing), .flushed(flushed)
    );

    always #5 CLK = ~CLK;

    // combinational tag lookup
    always_comb begin
        logic [2:0] rs;
        logic [0:0] rw;
        logic [2:0] ds;
        ds = dmemaddr[5:3];
        rs = flushing ? fl_set : ds;
        rw = flushing ? fl_way : victim;
        way_hit   = 2'b00;
        hit_dirty = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (mValid[ds][w] && mTag[ds][w] == dmemaddr[31:6]) begin
                way_hit[w] = 1'b1;
                hit_dirty  = mDirty[ds][w];
            end
        end
        victim_dirty = mValid[rs][rw] & mDirty[rs][rw];
        victim_tag   = mTag[rs][rw];
    end

    // array updates driven by the controller's strobes; arrays clear on reset
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < 8; s++) begin
                for (int w = 0; w < 2; w++) begin
                    mValid[s][w] <= 1'b0;
                    mDirty[s][w] <= 1'b0;
                    mTag[s][w]   <= '0;
                end
            end
        end else begin
            if (fill_en && word_idx == 1'b1) begin
                mValid[dmemaddr[5:3]][fill_way] <= 1'b1;
                mTag[dmemaddr[5:3]][fill_way]   <= dmemaddr[31:6];
                mDirty[dmemaddr[5:3]][fill_way] <= dmemWEN;
            end
            if (hit && dmemWEN)
                mDirty[dmemaddr[5:3]][way_hit[1] ? 1 : 0] <= 1'b1;
            if (clr_dirty) begin
                if (ccwait)        mDirty[ccsnoopaddr[5:3]][snoop_way] <= 1'b0;
                else if (flushing) mDirty[fl_set][fl_way] <= 1'b0;
                else               mDirty[dmemaddr[5:3]][fill_way] <= 1'b0;
            end
            if (inv_en && ccwait)
                mValid[ccsnoopaddr[5:3]][snoop_way] <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nAsserts++;
        assert (obs === expv) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chkZero(input string tag);
        chk(tag, {dREN, dWEN, cctrans, ccwrite, hit, fill_en, clr_dirty, inv_en,
                  flushing, flushed, daddr, word_idx, fl_set, fl_way, fill_way}, 64'd0);
    endtask

    function automatic logic setDwait(input int mode, input int wc);
        if (mode == 0) return 1'b0;
        if (mode == 1) return ($urandom_range(0, 2) == 0);
        return (wc < 2);
    endfunction

    // kind: 1 read, 2 write, 3 upgrade
    function automatic logic [33:0] busItem();
        logic [1:0] k;
        k = dWEN ? 2'd2 : (dREN ? 2'd1 : 2'd3);
        return {k, daddr};
    endfunction

    // one processor request, from presentation to hit
    task automatic req(input logic [31:0] a, input logic wr, input int vsel, input int mode);
        logic [33:0] expQ[$];
        logic [33:0] obsQ[$];
        int          s, hw, stalls, wc, hitIdx, expIdx;
        logic [0:0]  v, prevIdx;
        bit          got, prevStall, busAct;
        s  = int'(a[5:3]);
        hw = -1;
        for (int w = 0; w < 2; w++)
            if (mValid[s][w] && mTag[s][w] == a[31:6]) hw = w;
        v = (vsel < 0) ? 1'($urandom_range(0, 1)) : 1'(vsel);
        if (hw >= 0) begin
            if (wr && !mDirty[s][hw]) expQ.push_back({2'd3, a});
        end else begin
            if (mValid[s][v] && mDirty[s][v])
                for (int w = 0; w < 2; w++) expQ.push_back({2'd2, mTag[s][v], a[5:3], 1'(w), 2'b00});
            for (int w = 0; w < 2; w++) expQ.push_back({2'd1, a[31:3], 1'(w), 2'b00});
        end
        @(negedge CLK);
        dmemaddr = a; dmemREN = !wr; dmemWEN = wr; victim = v;
        got = 0; stalls = 0; wc = 0; prevStall = 0; hitIdx = -1; prevIdx = '0;
        for (int i = 0; i < 200; i++) begin
            if (i > 0) @(negedge CLK);
            dwait = setDwait(mode, wc);
            #1;
            busAct = dREN | dWEN | cctrans;
            if (busAct && prevStall) chk("hold_word_idx", word_idx, prevIdx);
            if (fill_en) chk("fill_way", fill_way, v);
            if (dREN) chk("fetch_ccwrite", ccwrite, wr);
            if (cctrans && !dREN && !dWEN) chk("upg_ccwrite", ccwrite, 1);
            if (dWEN && word_idx == 1'b1) chk("wb_clr_dirty", clr_dirty, 1);
            if (busAct && dwait) begin
                stalls++; wc++;
            end else if (busAct) begin
                obsQ.push_back(busItem()); wc = 0;
            end
            prevStall = busAct && dwait;
            prevIdx   = word_idx;
            if (hit) begin got = 1; hitIdx = i; break; end
        end
        expIdx = (expQ.size() == 0) ? 0 : expQ.size() + stalls + 1;
        chk("hit_seen", got, 1);
        chk("bus_count", obsQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) chk("bus_xfer", obsQ[i], expQ[i]);
        chk("hit_latency", hitIdx, expIdx);
        @(posedge CLK); #1;
        dmemREN = 0; dmemWEN = 0; dwait = 0;
    endtask

    // one snoop, optionally racing a processor request
    task automatic snoop(input logic [31:0] a, input logic inv, input bit withReq, input logic [31:0] ra);
        logic [33:0] expQ[$];
        logic [33:0] obsQ[$];
        int          s, hw;
        bit          hd, done;
        s  = int'(a[5:3]);
        hw = -1;
        for (int w = 0; w < 2; w++)
            if (mValid[s][w] && mTag[s][w] == a[31:6]) hw = w;
        hd = (hw >= 0) && mDirty[s][hw];
        if (hd) for (int w = 0; w < 2; w++) expQ.push_back({2'd2, a[31:3], 1'(w), 2'b00});
        @(negedge CLK);
        ccwait = 1; ccsnoopaddr = a; ccinv = inv;
        snoop_hit = (hw >= 0); snoop_way = (hw >= 0) ? 1'(hw) : 1'b0; snoop_dirty = hd;
        if (withReq) begin dmemaddr = ra; dmemREN = 1; victim = 0; end
        done = 0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge CLK);
            dwait = ($urandom_range(0, 2) == 0);
            #1;
            chk("snoop_no_hit", hit, 0);
            if (!hd) begin
                chk("snoop_inv_en", inv_en, (hw >= 0) && inv);
                chk("snoop_no_bus", dREN | dWEN | cctrans, 0);
                done = 1;
                break;
            end
            if (dWEN && !dwait) begin
                obsQ.push_back(busItem());
                if (obsQ.size() == 2) begin
                    chk("snoop_clr_dirty", clr_dirty, 1);
                    chk("snoop_last_inv", inv_en, inv);
                    done = 1;
                    break;
                end
            end
        end
        chk("snoop_done", done, 1);
        chk("snoop_count", obsQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) chk("snoop_xfer", obsQ[i], expQ[i]);
        @(posedge CLK); #1;
        ccwait = 0; snoop_hit = 0; snoop_dirty = 0; ccinv = 0; dwait = 0;
    endtask

    task automatic flush();
        logic [33:0] expQ[$];
        logic [33:0] obsQ[$];
        bit got;
        int cnt;
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++)
                if (mValid[s][w] && mDirty[s][w])
                    for (int k = 0; k < 2; k++) expQ.push_back({2'd2, mTag[s][w], 3'(s), 1'(k), 2'b00});
        @(negedge CLK);
        halt = 1;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            if (i > 0) @(negedge CLK);
            dwait = ($urandom_range(0, 2) == 0);
            #1;
            if (dWEN) chk("flushing_in_wb", flushing, 1);
            if (dWEN && !dwait) obsQ.push_back(busItem());
            if (flushed) begin got = 1; break; end
        end
        chk("flushed_seen", got, 1);
        chk("flushing_low", flushing, 0);
        chk("flush_count", obsQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) chk("flush_xfer", obsQ[i], expQ[i]);
        cnt = 0;
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++)
                if (mValid[s][w] && mDirty[s][w]) cnt++;
        chk("flush_left_dirty", cnt, 0);
        halt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); #1;
            chk("flushed_sticky", {flushed, dREN, dWEN}, 3'b100);
        end
    endtask

    task automatic pulseReset();
        @(negedge CLK);
        nRST = 0;
        @(negedge CLK);
        nRST = 1;
    endtask

    initial begin
        logic [31:0] a;
        nRST = 0; dmemREN = 0; dmemWEN = 0; halt = 0; dmemaddr = '0; victim = '0;
        dwait = 0; ccwait = 0; ccinv = 0; ccsnoopaddr = '0; snoop_way = '0;
        snoop_hit = 0; snoop_dirty = 0;
        @(negedge CLK); @(negedge CLK); #1;
        chkZero("reset_outputs");
        nRST = 1;
        @(negedge CLK); #1;
        chkZero("idle_after_reset");

        // clean read miss, zero-wait: 0x40, 0x44, hit in cycle 3
        req(32'h40, 0, 1, 0);
        // make set 0 way 1 hold dirty tag 5, then dirty-victim miss with 2-cycle waits
        req(32'h140, 1, 1, 1);
        req(32'h40, 0, 1, 2);
        // clean write hit upgrades, then dirty write hit is immediate
        req(32'h40, 1, 0, 2);
        req(32'h40, 1, 0, 1);
        // dirty snoop with invalidate racing a miss
        req(32'h88, 1, 0, 1);
        snoop(32'h88, 1, 1, 32'h2000);
        req(32'h2000, 0, 0, 1);

        for (int k = 0; k < 60; k++) begin
            a = {26'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'b00};
            if ($urandom_range(0, 9) < 8) req(a, 1'($urandom_range(0, 1)), -1, 1);
            else snoop(a, 1'($urandom_range(0, 1)), 0, 32'h0);
        end

        // reset in the middle of the second fetch word
        pulseReset();
        @(negedge CLK);
        dmemaddr = 32'h40; dmemREN = 1; victim = 0; dwait = 0;
        @(negedge CLK);
        @(negedge CLK);
        dwait = 1;
        #1;
        chk("pre_reset_fetch", {dREN, word_idx, daddr}, {1'b1, 1'b1, 32'h44});
        nRST = 0;
        #1;
        chkZero("reset_mid_fetch");
        dmemREN = 0; dwait = 0;
        @(negedge CLK);
        nRST = 1;
        req(32'h40, 0, 0, 1);

        // flush: only (set 3, way 1) and (set 7, way 0) dirty
        pulseReset();
        req(32'h58, 1, 1, 1);
        req(32'hB8, 1, 0, 1);
        req(32'h68, 0, 0, 1);
        flush();
        @(negedge CLK);
        nRST = 0;
        #1;
        chkZero("reset_after_halt");
        @(negedge CLK);
        nRST = 1;
        @(negedge CLK); #1;
        chkZero("idle_after_halt_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl_fsm.md
# dcache_ctrl_fsm

Parametrised data-cache controller FSM for the coherent pipeline. It generalises the two-way, two-word control FSM to WAYS-way and BLKWORDS-word blocks, and adds two behaviours: a write-upgrade bus transaction, and an iterative dirty flush on halt. It sits between the dcache tag/data arrays (datapath) and the coherence controller / memory bus. It issues word-granular bus reads and writes, services snoops, and sequences fills and write-backs.

## Interface
Parameters:
- WAYS, 2, associativity (power of 2, ≥2); WAYW = log2(WAYS)
- BLKWORDS, 2, words per block (power of 2, ≥2); OFFW = log2(BLKWORDS)
- SETS, 8, sets (power of 2); IDXW = log2(SETS); TAGW = 30 − OFFW − IDXW (derived localparam)

Ports:
- CLK in 1 — clock, rising edge
- nRST in 1 — reset, asynchronous, active-low
- dmemREN, dmemWEN in 1 — processor read/write request, held until hit
- dmemaddr in 32 — request address {tag, index, word, 2'b00}
- halt in 1 — processor halted; triggers flush
- way_hit in WAYS — one-hot valid&tag-match for dmemaddr set
- hit_dirty in 1 — hit block is Modified
- victim in WAYW — LRU victim way of dmemaddr set
- victim_dirty, victim_tag in 1, TAGW — state of entry under victim (or under fl_set/fl_way during flush)
- dwait in 1 — bus busy; a word transfer completes on a cycle with dREN|dWEN|cctrans high and dwait low
- ccwait in 1 — snoop request pending
- ccinv in 1 — snoop requires invalidate
- ccsnoopaddr in 32 — snooped address
- snoop_way in WAYW, snoop_hit in 1, snoop_dirty in 1 — datapath lookup of ccsnoopaddr
- dREN, dWEN out 1 — bus word read/write
- daddr out 32 — bus word address
- cctrans, ccwrite out 1 — coherence transaction active / intent-to-modify
- hit out 1 — request satisfied this cycle (datapath performs read/write)
- fill_en out 1, fill_way out WAYW, word_idx out OFFW — write fetched word, set valid on last word
- clr_dirty, inv_en out 1 — clear dirty / valid of entry addressed by current context way
- fl_set out IDXW, fl_way out WAYW — flush entry pointer
- flushing, flushed out 1

## Operation
- States: IDLE, WB, FETCH, UPG, SNP_WB, FL_CHK, FL_WB, HALTED.
- IDLE priority: ccwait > request > halt.
- Snoop in IDLE or FL_CHK:
  - snoop_hit & snoop_dirty → SNP_WB: write BLKWORDS words to {ccsnoopaddr[31:2+OFFW], word_idx, 00}. Then clr_dirty (plus inv_en if ccinv) on the last-word cycle, and return to the originating state.
  - Otherwise one cycle in place: inv_en = snoop_hit & ccinv.
- Request in IDLE, no snoop:
  - |way_hit and (dmemREN or hit_dirty) → hit=1.
  - Write hit with !hit_dirty → UPG: cctrans=ccwrite=1, daddr=dmemaddr until dwait low, then IDLE (hit the following cycle).
  - Miss: victim_dirty → WB, else FETCH.
- WB: dWEN, daddr={victim_tag, index, word_idx, 00}, cctrans=1. After the last word, clr_dirty and go to FETCH.
- FETCH: dREN, daddr={dmemaddr block, word_idx, 00}, cctrans=1, ccwrite=dmemWEN, fill_en/fill_way=victim on each completing word. After the last word, go to IDLE.
- word_idx counts 0..BLKWORDS−1, advances only on word completion, and resets to 0 on entry to any transfer state.
- victim is latched on miss detection and held through WB/FETCH.
- Halt in IDLE with no request → flushing=1, FL_CHK at fl_set=0, fl_way=0.
  - FL_CHK: victim_dirty → FL_WB, which writes {victim_tag, fl_set, word_idx, 00} then clr_dirty. Otherwise advance.
  - Advance order: fl_way increments first, then fl_set.
  - After entry (SETS−1, WAYS−1) → HALTED: flushed=1, flushing=0. HALTED is terminal until reset.
- ccwait is never asserted while cctrans is high (arbiter guarantee). It is ignored in WB/FETCH/UPG/FL_WB.

## Timing
- Reset: state IDLE, all outputs 0, word_idx=fl_set=fl_way=0, latched victim 0.
- hit is combinational in IDLE; hit latency is 0 cycles.
- Miss latency = (dirty ? BLKWORDS : 0) + BLKWORDS word completions + 1 IDLE cycle.
- Outputs are Moore from state and counters, except hit and inv_en in IDLE (Mealy on inputs).
- A dwait-low cycle on the last word performs the state transition on that same edge. With zero-wait memory, a clean miss therefore costs BLKWORDS+1 cycles.
- nRST asserted mid-transfer aborts immediately. No bus signal is held after reset.

## Test plan
- WAYS=2, BLKWORDS=2, SETS=8, dwait=0: read 0x0000_0040 with way_hit=00, victim=1, victim_dirty=0 → dREN at 0x40 then 0x44, fill_way=1, word_idx 0,1, hit in cycle 3.
- Same address with victim_dirty=1, victim_tag=0x5 → dWEN at 0x140 then 0x144, clr_dirty, then FETCH 0x40/0x44. With dwait=1 for 2 cycles per word, the counter holds.
- Write hit, hit_dirty=0 → UPG: cctrans=ccwrite=1, daddr=0x40 until dwait low, then hit=1. With hit_dirty=1 → hit same cycle, no bus activity.
- ccwait with snoop_hit=1, snoop_dirty=1, ccinv=1, ccsnoopaddr=0x88, simultaneous with a miss → SNP_WB writes 0x88, 0x8C, clr_dirty+inv_en, then the miss is serviced.
- halt with entries (set 3, way 1) and (set 7, way 0) dirty → only those are written back. flushed rises after 16 entries and stays high until nRST.
- nRST low during FETCH word 1 → all outputs 0 asynchronously. After release the FSM is in IDLE and the same request refetches from word 0.
